// File: rtl/uart_boot_loader_if.sv
// Boot-loader bus: UART RX FIFO head/pop, RAM write port and CPU control.
// The loader drives the master side; the FIFO/RAM/CPU environment is the slave.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 11
);
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_we;
    logic              cpu_hold;
    logic              done;

    modport master (
        input  rx_empty, r_data,
        output rd_uart, ram_addr, ram_wdata, ram_we, cpu_hold, done
    );

    modport slave (
        output rx_empty, r_data,
        input  rd_uart, ram_addr, ram_wdata, ram_we, cpu_hold, done
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Copies a length-prefixed byte stream from the UART RX FIFO into RAM while
// holding the CPU in reset, then releases the CPU and leaves the UART alone.
module uart_boot_loader #(
    parameter int         ADDR_W    = 11,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               reset,
    uart_boot_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        word_q [4];
    logic [3:0]        lane_we;
    logic              pop_prev_q;
    logic              pop;
    logic              can_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_SYNC;
            len_q      <= '0;
            idx_q      <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pop_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pop_prev_q <= pop;
        end
    end

    // One byte register per lane so a stale partial word never survives a reset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (!reset) begin
                word_q[gi] <= '0;
            end else if (lane_we[gi]) begin
                word_q[gi] <= bus.r_data;
            end
        end
    end

    // Pops are gated by reset so the FIFO never loses a byte while held.
    assign can_pop = !bus.rx_empty && !pop_prev_q && reset;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lane_we = 4'b0000;
        pop     = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (can_pop) begin
                    pop = 1'b1;
                    if (bus.r_data == SYNC_BYTE) begin
                        state_d = S_LEN_LO;
                    end
                end
            end
            S_LEN_LO: begin
                if (can_pop) begin
                    pop        = 1'b1;
                    len_d[7:0] = bus.r_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (can_pop) begin
                    pop         = 1'b1;
                    len_d[15:8] = bus.r_data;
                    state_d     = ({bus.r_data, len_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (can_pop) begin
                    pop             = 1'b1;
                    lane_we[lane_q] = 1'b1;
                    lane_d          = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = idx_q[ADDR_W-1:0];
                        wdata_d = {bus.r_data, word_q[2], word_q[1], word_q[0]};
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q + 16'd1 == len_q) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase
    end

    // Words past the end of RAM are still consumed and counted, just not written.
    assign bus.ram_we    = (state_q == S_WRITE && {1'b0, idx_q} < DEPTH) ? 4'hF : 4'h0;
    assign bus.rd_uart   = pop;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.cpu_hold  = (state_q != S_DONE);
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: a table of byte streams on an ADDR_W=11
// instance, plus mid-word reset and RAM-overflow sequences (ADDR_W=2 instance).
module tb_uart_boot_loader;
    typedef struct packed {
        logic [7:0]   nbytes;
        logic [127:0] bytes;   // stream byte j at [8*j +: 8]
        logic         gaps;
        logic [2:0]   nw;
        logic [127:0] words;   // expected word i at [32*i +: 32]
        logic [7:0]   npops;
    } vec_t;

    typedef struct {
        int          inst;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } wr_t;

    localparam int NV = 5;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic gap_en;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;
    logic [7:0] fq_a[$];
    logic [7:0] fq_b[$];
    wr_t wlog[$];
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc [2];
    int pops [2];
    int last_pop [2];
    int last_wr [2];
    int done_cyc [2];
    int b2b [2];
    int bad_hold [2];
    int bad_we [2];
    logic prev_rd [2];

    uart_boot_loader_if #(.ADDR_W(11)) ifa ();
    uart_boot_loader_if #(.ADDR_W(2))  ifb ();

    uart_boot_loader #(.ADDR_W(11), .SYNC_BYTE(8'hA5)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    uart_boot_loader #(.ADDR_W(2),  .SYNC_BYTE(8'hA5)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input int k);
        cyc[k] = 0; pops[k] = 0; last_pop[k] = -1; last_wr[k] = -1;
        done_cyc[k] = -1; b2b[k] = 0; bad_hold[k] = 0; bad_we[k] = 0;
        prev_rd[k] = 1'b0;
    endtask

    task automatic mon(input int k, input logic rd, input logic [3:0] we, input logic [15:0] addr,
                       input logic [31:0] wd, input logic dn, input logic hold);
        cyc[k]++;
        if (rd) begin
            pops[k]++;
            last_pop[k] = cyc[k];
            if (prev_rd[k]) b2b[k]++;
        end
        prev_rd[k] = rd;
        if (we != 4'h0) begin
            wlog.push_back('{k, addr, wd, we});
            last_wr[k] = cyc[k];
            $display("write inst=%0d addr=%h wdata=%h we=%h", k, addr, wd, we);
        end
        if ((we != 4'h0 && we != 4'hF) || (dn && we != 4'h0)) bad_we[k]++;
        if (dn && done_cyc[k] < 0) done_cyc[k] = cyc[k];
        if (dn == hold) bad_hold[k]++;
    endtask

    // FIFO model: pops what the DUT popped at the last edge, presents the next head.
    always @(negedge clk) begin
        if (pend_a) void'(fq_a.pop_front());
        if (pend_b) void'(fq_b.pop_front());
        ifa.rx_empty = (fq_a.size() == 0) || (gap_en && $urandom_range(0, 1) == 1);
        ifa.r_data   = (fq_a.size() != 0) ? fq_a[0] : 8'h00;
        ifb.rx_empty = (fq_b.size() == 0);
        ifb.r_data   = (fq_b.size() != 0) ? fq_b[0] : 8'h00;
        #1;
        pend_a = ifa.rd_uart;
        pend_b = ifb.rd_uart;
        mon(0, ifa.rd_uart, ifa.ram_we, 16'(ifa.ram_addr), ifa.ram_wdata, ifa.done, ifa.cpu_hold);
        mon(1, ifb.rd_uart, ifb.ram_we, 16'(ifb.ram_addr), ifb.ram_wdata, ifb.done, ifb.cpu_hold);
    end

    task automatic check_writes(input string tag, input int k, input int nw, input logic [127:0] words);
        int j;
        j = 0;
        foreach (wlog[e]) begin
            if (wlog[e].inst == k) begin
                if (j < nw) begin
                    chk({tag, " addr"}, 32'(wlog[e].addr), 32'(j));
                    chk({tag, " wdata"}, wlog[e].wdata, words[32*j +: 32]);
                    chk({tag, " we"}, 32'(wlog[e].we), 32'hF);
                end
                j++;
            end
        end
        chk({tag, " write count"}, 32'(j), 32'(nw));
    endtask

    task automatic check_end(input string tag, input int k, input int nw, input int npops);
        chk({tag, " pops"}, 32'(pops[k]), 32'(npops));
        chk({tag, " back-to-back pops"}, 32'(b2b[k]), 32'd0);
        chk({tag, " done vs cpu_hold"}, 32'(bad_hold[k]), 32'd0);
        chk({tag, " ram_we outside write"}, 32'(bad_we[k]), 32'd0);
        chk({tag, " done latency"}, 32'(done_cyc[k] - last_pop[k]), (nw > 0) ? 32'd2 : 32'd1);
    endtask

    task automatic wait_done(input int k);
        for (int c = 0; c < 800; c++) begin
            if ((k == 0) ? ifa.done : ifb.done) break;
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        #2;
    endtask

    task automatic run_row(input int i);
        vec_t v;
        string tag;
        v = vecs[i];
        tag = $sformatf("row%0d", i);
        @(negedge clk);
        rst_a  = 1'b0;
        gap_en = v.gaps;
        fq_a.delete();
        repeat (2) @(negedge clk);
        for (int j = 0; j < int'(v.nbytes); j++) fq_a.push_back(v.bytes[8*j +: 8]);
        @(negedge clk);
        #2;
        chk({tag, " reset cpu_hold"}, 32'(ifa.cpu_hold), 32'd1);
        chk({tag, " reset done"}, 32'(ifa.done), 32'd0);
        chk({tag, " reset rd_uart"}, 32'(ifa.rd_uart), 32'd0);
        chk({tag, " reset ram_we"}, 32'(ifa.ram_we), 32'd0);
        chk({tag, " reset ram_addr"}, 32'(ifa.ram_addr), 32'd0);
        chk({tag, " reset ram_wdata"}, ifa.ram_wdata, 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        clear_mon(0);
        wlog.delete();
        wait_done(0);
        chk({tag, " done"}, 32'(ifa.done), 32'd1);
        chk({tag, " cpu_hold"}, 32'(ifa.cpu_hold), 32'd0);
        chk({tag, " fifo left"}, 32'(fq_a.size()), 32'(int'(v.nbytes) - int'(v.npops)));
        check_writes(tag, 0, int'(v.nw), v.words);
        check_end(tag, 0, int'(v.nw), int'(v.npops));
        if (v.nw != 0) chk({tag, " done after write"}, 32'(done_cyc[0] - last_wr[0]), 32'd1);
        $display("case %s: bytes=%0d pops=%0d writes=%0d done=%0b", tag, v.nbytes, pops[0], v.nw, ifa.done);
    endtask

    initial begin
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        gap_en = 1'b0;
        clear_mon(0);
        clear_mon(1);
        vecs[0] = '{nbytes: 8'd9,  bytes: 128'hDEADBEEF_0001A512_00, gaps: 1'b0, nw: 3'd1,
                    words: 128'hDEADBEEF, npops: 8'd9};
        vecs[1] = '{nbytes: 8'd5,  bytes: 128'h88_77_0000_A5, gaps: 1'b0, nw: 3'd0,
                    words: 128'h0, npops: 8'd3};
        vecs[2] = '{nbytes: 8'd15, bytes: 128'hCCBBAA99_88776655_44332211_0003A5, gaps: 1'b1, nw: 3'd3,
                    words: 128'hCCBBAA99_88776655_44332211, npops: 8'd15};
        vecs[3] = '{nbytes: 8'd12, bytes: 128'hC0D0E0F0_04030201_0002A55A, gaps: 1'b0, nw: 3'd2,
                    words: 128'hC0D0E0F0_04030201, npops: 8'd12};
        vecs[4] = '{nbytes: 8'd8,  bytes: 128'h3C_A5A5A5A5_0001A5, gaps: 1'b1, nw: 3'd1,
                    words: 128'hA5A5A5A5, npops: 8'd7};

        for (int i = 0; i < NV; i++) run_row(i);

        // Reset in the middle of the first word, then a clean image.
        @(negedge clk);
        rst_a  = 1'b0;
        gap_en = 1'b0;
        fq_a.delete();
        repeat (2) @(negedge clk);
        fq_a = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        @(negedge clk);
        rst_a = 1'b1;
        clear_mon(0);
        for (int c = 0; c < 200 && pops[0] < 5; c++) @(negedge clk);
        chk("midword pops before reset", 32'(pops[0]), 32'd5);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        fq_a = '{8'h00, 8'h12, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        @(negedge clk);
        rst_a = 1'b1;
        clear_mon(0);
        wlog.delete();
        wait_done(0);
        chk("midword done", 32'(ifa.done), 32'd1);
        check_writes("midword", 0, 1, 128'hDEADBEEF);
        check_end("midword", 0, 1, 9);
        $display("case midword: pops=%0d done=%0b", pops[0], ifa.done);

        // Five words into a four-word RAM: the fifth is consumed without a write.
        fq_b.delete();
        fq_b.push_back(8'hA5);
        fq_b.push_back(8'h05);
        fq_b.push_back(8'h00);
        for (int j = 0; j < 20; j++) fq_b.push_back(8'(8'h10 + j));
        @(negedge clk);
        rst_b = 1'b1;
        clear_mon(1);
        wlog.delete();
        wait_done(1);
        chk("overflow done", 32'(ifb.done), 32'd1);
        chk("overflow cpu_hold", 32'(ifb.cpu_hold), 32'd0);
        chk("overflow fifo left", 32'(fq_b.size()), 32'd0);
        check_writes("overflow", 1, 4, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        check_end("overflow", 1, 5, 23);
        $display("case overflow: pops=%0d done=%0b", pops[1], ifb.done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
